// File: rtl/mux16_scan_seq_if.sv
// Scan bundle between the 16:1 mux read-back sequencer and its environment.
// master: the sequencer side (drives sel and the result); slave: mux/requester side.
// Control inputs are level-sampled by the sequencer on the rising clock edge.
interface mux16_scan_seq_if;
    logic        start;
    logic        abort;
    logic [3:0]  sel;
    logic        mux_out;
    logic        busy;
    logic        done;
    logic [15:0] data;

    modport master (
        input  start,
        input  abort,
        input  mux_out,
        output sel,
        output busy,
        output done,
        output data
    );

    modport slave (
        output start,
        output abort,
        output mux_out,
        input  sel,
        input  busy,
        input  done,
        input  data
    );
endinterface

// File: rtl/mux16_scan_seq.sv
// Steps a 16:1 mux select through 0..15, samples mux_out per select, reassembles the word.
// Latency: done is high in the cycle after edge E0+16*(SETTLE+1), E0 being the start edge.
// No backpressure: start is ignored unless idle; abort cancels a scan without a done pulse.
module mux16_scan_seq #(
    parameter int SETTLE = 0,
    parameter int CW     = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux16_scan_seq_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // With no settle delay the sequencer samples on every cycle and WAIT is never entered.
    localparam bit            LP_NO_SETTLE = (SETTLE == 0);
    localparam logic [CW-1:0] LP_RELOAD    = LP_NO_SETTLE ? '0 : CW'(SETTLE - 1);

    state_t        r_state;
    logic [3:0]    r_sel;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_shadow;
    logic [15:0]   r_data;
    logic          r_busy;
    logic          r_done;

    logic          w_last;

    assign w_last   = (r_sel == 4'd15);

    assign bus.sel  = r_sel;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.data = r_data;

    // Scan FSM: all outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sel    <= 4'd0;
            r_cnt    <= '0;
            r_shadow <= 16'h0000;
            r_data   <= 16'h0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sel  <= 4'd0;
                    r_done <= 1'b0;
                    // abort takes priority: a simultaneous start is dropped.
                    if (!bus.abort && bus.start) begin
                        r_shadow <= 16'h0000;
                        r_busy   <= 1'b1;
                        if (LP_NO_SETTLE) begin
                            r_state <= ST_SAMPLE;
                        end else begin
                            r_cnt   <= LP_RELOAD;
                            r_state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_sel   <= 4'd0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    if (bus.abort) begin
                        // Partial shadow is simply left behind; it is cleared on the next start.
                        r_state <= ST_IDLE;
                        r_sel   <= 4'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_shadow[r_sel] <= bus.mux_out;
                        if (w_last) begin
                            // Bit 15 is taken straight from the mux: the shadow write lands this same edge.
                            r_data  <= {bus.mux_out, r_shadow[14:0]};
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_sel <= r_sel + 4'd1;
                            if (!LP_NO_SETTLE) begin
                                r_cnt   <= LP_RELOAD;
                                r_state <= ST_WAIT;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    // One-cycle pulse; start and abort are both ignored here.
                    r_done  <= 1'b0;
                    r_sel   <= 4'd0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_sel   <= 4'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
